cpu_run_ctrl: RTL

//  Synthesizable program-load / run controller for the FRANK6000 CPU. Replaces bench-only plumbing:

---
 rtl/cpu_run_ctrl_pkg.sv | 25 ++
 rtl/cpu_run_ctrl_en_div.sv | 30 +++
 rtl/cpu_run_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the FRANK6000 run controller: controller state
// encoding and the default widths/timing that the CPU top also uses.
package cpu_run_ctrl_pkg;

  localparam int FRANK_ADDR_W  = 8;
  localparam int FRANK_INSTR_W = 16;
  localparam int FRANK_DATA_W  = 8;
  localparam int FRANK_EN_DIV  = 4;
  localparam int FRANK_RST_CYC = 2;
  localparam int FRANK_STEP_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RESET = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

  // States from which a new load or run may be launched.
  function automatic logic can_launch(input run_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_en_div.sv
// Control-enable divider: one-cycle enable every EN_DIV clocks, the enable
// lands on the first cycle after i_clr is released.
module cpu_run_ctrl_en_div #(
  parameter int EN_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_en
);

  localparam int CW = (EN_DIV > 1) ? $clog2(EN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(EN_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-EN_DIV counter, parked at zero while cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_en = (cnt == '0) && !i_clr;

endmodule

// File: rtl/cpu_run_ctrl.sv
// FRANK6000 program-load / run controller. Streams program words into the
// instruction memory, sequences CPU reset, gates the divided control enable,
// counts control steps and stops on the CPU loop flag or a step limit.
//
// Load handshake: a beat transfers on any cycle where i_ld_valid and
// o_ld_ready are both high; o_ld_ready depends only on controller state, the
// source may hold valid high indefinitely and must keep data/last stable until
// the beat transfers.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W  = FRANK_ADDR_W,
  parameter int INSTR_W = FRANK_INSTR_W,
  parameter int DATA_W  = FRANK_DATA_W,
  parameter int EN_DIV  = FRANK_EN_DIV,
  parameter int RST_CYC = FRANK_RST_CYC,
  parameter int STEP_W  = FRANK_STEP_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_ld_valid,
  input  logic [INSTR_W-1:0] i_ld_data,
  input  logic               i_ld_last,
  output logic               o_ld_ready,
  input  logic [STEP_W-1:0]  i_max_steps,
  input  logic               i_loopf,
  input  logic [DATA_W-1:0]  i_WREG,
  output logic [ADDR_W-1:0]  o_instr_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_we,
  output logic               o_cpu_rst,
  output logic               o_ON,
  output logic               o_control_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic [DATA_W-1:0]  o_result,
  output logic [STEP_W-1:0]  o_steps,
  output logic [ADDR_W:0]    o_prog_len,
  output logic [2:0]         o_dbg_state
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

  run_state_t        state_q;
  run_state_t        state_d;
  logic [ADDR_W-1:0] addr;
  logic [RCW-1:0]    rst_cnt;
  logic [STEP_W-1:0] limit;
  logic [STEP_W-1:0] steps_inc;
  logic              loopf_q;
  logic              div_en;
  logic              beat;
  logic              last_addr;
  logic              run_en;
  logic              loop_rise;
  logic              limit_hit;

  // The divider only counts in RUN so the first RUN cycle always enables.
  cpu_run_ctrl_en_div #(
    .EN_DIV (EN_DIV)
  ) u_en_div (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_q != ST_RUN),
    .o_en  (div_en)
  );

  assign beat      = (state_q == ST_LOAD) && i_ld_valid;
  assign last_addr = (addr == {ADDR_W{1'b1}});
  assign run_en    = (state_q == ST_RUN) && div_en;
  assign steps_inc = (o_steps == {STEP_W{1'b1}}) ? o_steps : o_steps + 1'b1;
  assign loop_rise = (state_q == ST_RUN) && i_loopf && !loopf_q;
  // The limit is reached on the enable that brings the step count up to it.
  assign limit_hit = run_en && (limit != '0) && (steps_inc == limit);

  assign o_control_en = run_en;
  assign o_dbg_state  = state_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and state-decoded outputs; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    o_ld_ready = 1'b0;
    o_cpu_rst  = 1'b1;
    o_ON       = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        o_cpu_rst = (state_q == ST_IDLE);
        if (i_load) begin
          state_d = ST_LOAD;
        end else if (i_start) begin
          state_d = ST_RESET;
        end
      end
      ST_LOAD: begin
        o_ld_ready = 1'b1;
        o_busy     = 1'b1;
        if (beat && (i_ld_last || last_addr)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESET: begin
        o_busy = 1'b1;
        if (rst_cnt == RST_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_cpu_rst = 1'b0;
        o_ON      = 1'b1;
        o_busy    = 1'b1;
        if (loop_rise || limit_hit) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (i_abort) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath: memory write port, load address/length, reset timer, step
  // counter, run limit, loop-flag history, result and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr         <= '0;
      rst_cnt      <= '0;
      limit        <= '0;
      loopf_q      <= 1'b0;
      o_instr_addr <= '0;
      o_instr      <= '0;
      o_instr_we   <= 1'b0;
      o_done       <= 1'b0;
      o_timeout    <= 1'b0;
      o_result     <= '0;
      o_steps      <= '0;
      o_prog_len   <= '0;
    end else begin
      loopf_q    <= i_loopf;
      o_instr_we <= 1'b0;
      if (i_abort) begin
        o_done    <= 1'b0;
        o_timeout <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (i_load) begin
              addr       <= '0;
              o_prog_len <= '0;
              o_done     <= 1'b0;
              o_timeout  <= 1'b0;
            end else if (can_launch(state_q) && i_start) begin
              limit     <= i_max_steps;
              rst_cnt   <= '0;
              o_steps   <= '0;
              o_result  <= '0;
              o_done    <= 1'b0;
              o_timeout <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (beat) begin
              o_instr_we   <= 1'b1;
              o_instr_addr <= addr;
              o_instr      <= i_ld_data;
              addr         <= addr + 1'b1;
              o_prog_len   <= o_prog_len + 1'b1;
            end
          end
          ST_RESET: begin
            if (rst_cnt != RST_LAST) begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (run_en) begin
              o_steps <= steps_inc;
            end
            if (loop_rise) begin
              o_result <= i_WREG;
              o_done   <= 1'b1;
            end else if (limit_hit) begin
              o_done    <= 1'b1;
              o_timeout <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
